// File: rtl/instruction_queue.sv
// In-order instruction queue between Fetch and the Parser: circular buffer with
// all-or-nothing bundle push, multi-lane issue and flush. IQ_STATS_EN adds a fetch-stall counter.
module instruction_queue #(
    parameter int INSTR_WIDTH = 30,
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8,
    parameter int PC_WIDTH    = 16
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               flush_i,
    input  logic                               fetchValid_i,
    input  logic [FETCH_WIDTH*INSTR_WIDTH-1:0] fetchData_i,
    input  logic [PC_WIDTH-1:0]                fetchPc_i,
    output logic                               fetchReady_o,
    output logic [ISSUE_WIDTH-1:0]             issueValid_o,
    output logic [ISSUE_WIDTH*INSTR_WIDTH-1:0] issueData_o,
    output logic [ISSUE_WIDTH*PC_WIDTH-1:0]    issuePc_o,
    input  logic                               issueReady_i,
    output logic [$clog2(DEPTH+1)-1:0]         count_o
`ifdef IQ_STATS_EN
    ,
    output logic [15:0]                        stallCount_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [INSTR_WIDTH-1:0] data_q [DEPTH];
    logic [INSTR_WIDTH-1:0] data_d [DEPTH];
    logic [PC_WIDTH-1:0]    pc_q   [DEPTH];
    logic [PC_WIDTH-1:0]    pc_d   [DEPTH];
    logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]          count_q, count_d, pop_n;
    logic                   push, pop;

    always_comb begin
        // Readiness looks only at the registered count, never at a same-cycle pop.
        fetchReady_o = (count_q <= CW'(DEPTH - FETCH_WIDTH));
        push         = fetchValid_i && fetchReady_o && !flush_i;
        pop          = issueReady_i && !flush_i;
        pop_n        = '0;
        if (pop) begin
            pop_n = (count_q < CW'(ISSUE_WIDTH)) ? count_q : CW'(ISSUE_WIDTH);
        end
        head_d  = head_q + PW'(pop_n);
        tail_d  = push ? tail_q + PW'(FETCH_WIDTH) : tail_q;
        count_d = count_q + (push ? CW'(FETCH_WIDTH) : '0) - pop_n;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            data_d[e] = data_q[e];
            pc_d[e]   = pc_q[e];
            if (push) begin
                for (int k = 0; k < FETCH_WIDTH; k++) begin
                    if (tail_q + PW'(k) == PW'(e)) begin
                        data_d[e] = fetchData_i[k*INSTR_WIDTH +: INSTR_WIDTH];
                        pc_d[e]   = fetchPc_i + PC_WIDTH'(k);
                    end
                end
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                data_q[e] <= '0;
                pc_q[e]   <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int e = 0; e < DEPTH; e++) begin
                data_q[e] <= data_d[e];
                pc_q[e]   <= pc_d[e];
            end
        end
    end

    // Issue lanes read storage combinationally; lane 0 is always the oldest entry.
    generate
        for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_lane
            logic [PW-1:0] rd_idx;
            assign rd_idx           = head_q + PW'(gi);
            assign issueValid_o[gi] = (count_q > CW'(gi));
            assign issueData_o[gi*INSTR_WIDTH +: INSTR_WIDTH] = data_q[rd_idx];
            assign issuePc_o[gi*PC_WIDTH +: PC_WIDTH]         = pc_q[rd_idx];
        end
    endgenerate

    assign count_o = count_q;

`ifdef IQ_STATS_EN
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (fetchValid_i && !fetchReady_o && !flush_i && stall_count_q != 16'hFFFF) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // Only reset clears the statistic; a flush leaves it alone.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stallCount_o = stall_count_q;
`endif

endmodule

// File: tb/tb_instruction_queue.sv
// Bench for instruction_queue: directed steps then random traffic, checked against
// a queue-based reference model of the occupancy, ordering and flush rules.
module tb_instruction_queue;

    logic        clk = 1'b0;
    logic        reset_i, flush_i, fetchValid_i, issueReady_i;
    logic [59:0] fetchData_i;
    logic [15:0] fetchPc_i;
    logic        fetchReady_o;
    logic [1:0]  issueValid_o;
    logic [59:0] issueData_o;
    logic [31:0] issuePc_o;
    logic [3:0]  count_o;
`ifdef IQ_STATS_EN
    logic [15:0] stallCount_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [29:0] mq_data[$];
    logic [15:0] mq_pc[$];
    int          m_stall = 0;

    always #5 clk = ~clk;

    instruction_queue dut (
        .clock_i      (clk),
        .reset_i      (reset_i),
        .flush_i      (flush_i),
        .fetchValid_i (fetchValid_i),
        .fetchData_i  (fetchData_i),
        .fetchPc_i    (fetchPc_i),
        .fetchReady_o (fetchReady_o),
        .issueValid_o (issueValid_o),
        .issueData_o  (issueData_o),
        .issuePc_o    (issuePc_o),
        .issueReady_i (issueReady_i),
        .count_o      (count_o)
`ifdef IQ_STATS_EN
        ,
        .stallCount_o (stallCount_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int sz = mq_data.size();
        chk("count", 64'(count_o), 64'(sz));
        chk("fetch_ready", 64'(fetchReady_o), 64'(sz <= 6));
        for (int l = 0; l < 2; l++) begin
            chk("lane_valid", 64'(issueValid_o[l]), 64'(sz > l));
            if (sz > l) begin
                chk("lane_data", 64'(issueData_o[l*30 +: 30]), 64'(mq_data[l]));
                chk("lane_pc", 64'(issuePc_o[l*16 +: 16]), 64'(mq_pc[l]));
            end
        end
`ifdef IQ_STATS_EN
        chk("stall_count", 64'(stallCount_o), 64'(m_stall));
`endif
    endtask

    // Called at a negedge: check, drive, update the model, advance one clock.
    task automatic cycle(input logic fv, input logic [59:0] fd, input logic [15:0] fpc,
                         input logic ir, input logic fl);
        bit rdy;
        int n;
        check_outputs();
        fetchValid_i = fv;
        fetchData_i  = fd;
        fetchPc_i    = fpc;
        issueReady_i = ir;
        flush_i      = fl;
        rdy = (mq_data.size() <= 6);
        if (fv && !rdy && !fl && m_stall != 16'hFFFF) m_stall++;
        if (fl) begin
            mq_data.delete();
            mq_pc.delete();
        end else begin
            if (ir) begin
                n = (mq_data.size() < 2) ? mq_data.size() : 2;
                repeat (n) begin
                    void'(mq_data.pop_front());
                    void'(mq_pc.pop_front());
                end
            end
            if (fv && rdy) begin
                for (int k = 0; k < 2; k++) begin
                    mq_data.push_back(fd[k*30 +: 30]);
                    mq_pc.push_back(fpc + 16'(k));
                end
            end
        end
        $display("txn fv=%0b pc=%0d ir=%0b fl=%0b -> model count %0d", fv, fpc, ir, fl, mq_data.size());
        @(negedge clk);
    endtask

    function automatic logic [59:0] rnd_bundle();
        return 60'({$urandom(), $urandom()});
    endfunction

    initial begin
        reset_i = 1'b1; flush_i = 1'b0; fetchValid_i = 1'b0; issueReady_i = 1'b0;
        fetchData_i = '0; fetchPc_i = '0;
        @(negedge clk); @(negedge clk);
        reset_i = 1'b0;

        // Fill to four entries, then reset asynchronously between clock edges.
        cycle(1'b1, rnd_bundle(), 16'd100, 1'b0, 1'b0);
        cycle(1'b1, rnd_bundle(), 16'd102, 1'b0, 1'b0);
        chk("pre_reset_count", 64'(count_o), 64'd4);
        #2 reset_i = 1'b1;
        #1;
        chk("async_reset_count", 64'(count_o), 64'd0);
        chk("async_reset_ready", 64'(fetchReady_o), 64'd1);
        chk("async_reset_valid", 64'(issueValid_o), 64'd0);
        chk("async_reset_data", 64'(issueData_o), 64'd0);
        chk("async_reset_pc", 64'(issuePc_o), 64'd0);
        mq_data.delete(); mq_pc.delete(); m_stall = 0;
        @(negedge clk);
        reset_i = 1'b0;

        // Fill to full, hold off a fifth bundle, then drain in order.
        for (int b = 0; b < 4; b++) cycle(1'b1, rnd_bundle(), 16'(2*b), 1'b0, 1'b0);
        repeat (10) cycle(1'b1, rnd_bundle(), 16'd8, 1'b0, 1'b0);
        chk("full_count", 64'(count_o), 64'd8);
        for (int b = 0; b < 4; b++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
        chk("drained_valid", 64'(issueValid_o), 64'd0);

        // Simultaneous push/pop at occupancy 6, and pointer wrap.
        for (int b = 0; b < 3; b++) cycle(1'b1, rnd_bundle(), 16'(20 + 2*b), 1'b0, 1'b0);
        cycle(1'b1, rnd_bundle(), 16'd26, 1'b1, 1'b0);
        chk("pushpop_count", 64'(count_o), 64'd6);
        for (int b = 0; b < 6; b++) cycle(1'b1, rnd_bundle(), 16'(28 + 2*b), 1'b1, 1'b0);

        // Flush with a bundle presented, then a fresh bundle at PC 40.
        cycle(1'b1, rnd_bundle(), 16'd90, 1'b1, 1'b1);
        chk("flush_count", 64'(count_o), 64'd0);
        chk("flush_valid", 64'(issueValid_o), 64'd0);
        cycle(1'b1, rnd_bundle(), 16'd40, 1'b0, 1'b0);
        chk("post_flush_pc0", 64'(issuePc_o[15:0]), 64'd40);
        chk("post_flush_pc1", 64'(issuePc_o[31:16]), 64'd41);

        // PC increment wraps modulo 2^16 inside a bundle.
        cycle(1'b1, rnd_bundle(), 16'hFFFF, 1'b1, 1'b0);

        // Random traffic.
        for (int t = 0; t < 400; t++) begin
            cycle(($urandom_range(0, 3) != 0), rnd_bundle(), 16'($urandom()),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 31) == 0));
        end
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
